tx_buf_sched: RTL and testbench
===============================

TX_BUF_SCHED -- requirements
Module: tx_buf_sched

Interface
REQ-001 SHALL have parameter TX_BUF_BADDR, default 32'h2000, meaning the base address of the tx PTP buffer; the control register is at TX_BUF_BADDR+32'h200.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning the minimum idle cycles after each frame.
REQ-003 SHALL have parameter POLL_LIMIT, default 1024, meaning the maximum number of control-register poll cycles before timeout.
REQ-004 SHALL have port bus2ip_clk, input, 1, clock.
REQ-005 SHALL have port bus2ip_rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 SHALL have port req_i, input, 3, frame request per source; source 0 carries event messages.
REQ-007 SHALL have port len_i, input, 27, frame length in octets, 9 bits per source; source n uses [9n+8:9n].
REQ-008 SHALL have port grant_o, input/output direction output, 3, one-hot grant to the source being served.
REQ-009 SHALL have port word_rd_o, output, 1, word-fetch strobe.
REQ-010 SHALL have port word_idx_o, output, 7, index of the fetched word within the granted source's frame.
REQ-011 SHALL have port word_data_i, input, 32, fetched word, valid combinationally in the same cycle as word_rd_o.
REQ-012 SHALL have port bus_addr_o, output, 32, bus master address.
REQ-013 SHALL have port bus_wdata_o, output, 32, bus master write data.
REQ-014 SHALL have port bus_wr_o, output, 1, write strobe (one word per cycle).
REQ-015 SHALL have port bus_rd_o, output, 1, read strobe.
REQ-016 SHALL have port bus_rdata_i, input, 32, read data, valid in the same cycle as bus_rd_o.
REQ-017 SHALL have port done_o, output, 3, one-cycle completion pulse per source.
REQ-018 SHALL have port err_o, output, 3, one-cycle error pulse per source (bad length or timeout).

Function
REQ-019 FSM states SHALL be IDLE, ARB, COPY, KICK, POLL, GAP.
REQ-020 IDLE->ARB SHALL occur when any req_i bit is 1.
REQ-021 ARB SHALL grant by priority: source 0 strictly first; sources 1 and 2 round-robin, with the pointer toggling after each grant to 1 or 2.
REQ-022 grant_o SHALL be set on ARB exit and held until the cycle after done_o or err_o; the selected len is latched at grant.
REQ-023 If the latched len is 0 or greater than 508, the block SHALL pulse err_o[src], skip COPY/KICK/POLL, and go to GAP.
REQ-024 The word count SHALL be nw = ceil(len/4) (maximum 127).
REQ-025 COPY SHALL issue one word per cycle, idx 0..nw-1, with word_rd_o=1, word_idx_o=idx, bus_wr_o=1, bus_addr_o=TX_BUF_BADDR+4*idx, and bus_wdata_o=word_data_i.
REQ-026 COPY SHALL last exactly nw cycles.
REQ-027 KICK SHALL last one cycle with bus_wr_o=1, bus_addr_o=TX_BUF_BADDR+32'h200, and bus_wdata_o={16'b0,1'b1,6'b0,len[8:0]}.
REQ-028 POLL SHALL assert bus_rd_o=1 at the control address every cycle.
REQ-029 POLL SHALL exit to GAP with done_o[src]=1 on the first cycle in which bus_rdata_i[15]==0 and at least 2 poll cycles have elapsed.
REQ-030 If POLL_LIMIT poll cycles elapse without bit 15 clearing, the block SHALL pulse err_o[src] and go to GAP.
REQ-031 GAP SHALL wait GAP_CYCLES+nw cycles (GAP_CYCLES only on a length error), then go to IDLE; grant_o SHALL be 0 in GAP.
REQ-032 A req_i deassertion after grant SHALL NOT abort the frame; it completes normally.
REQ-033 New requests during COPY..GAP SHALL be held pending and arbitrated on the next ARB.
REQ-034 bus_wr_o and bus_rd_o SHALL never be 1 in the same cycle.
REQ-035 The address and data outputs SHALL be 0 whenever their strobes are 0.
REQ-036 All counters SHALL be sized so that they do not wrap within POLL_LIMIT or GAP_CYCLES+127.

Reset
REQ-037 On bus2ip_rst_n=0, at any time, the block SHALL asynchronously go to IDLE, with grant_o, word_rd_o, bus_wr_o, bus_rd_o, done_o, err_o, bus_addr_o, bus_wdata_o, and word_idx_o all 0, and the round-robin pointer set to source 1.
REQ-038 A reset mid-operation SHALL abandon the frame without a done or err pulse.
REQ-039 After reset release, the block SHALL begin arbitration at the first clock edge with req_i nonzero.

Verification
REQ-040 req_i=3'b001, len=60 -> 15 writes to 0x2000..0x2038, then a KICK write of 0x0000803C to 0x2200; with bit15 read back as 0 -> one-cycle done_o=001, then 31 GAP cycles.
REQ-041 req_i=3'b110 held, len=64 each -> grants alternate 010, 100, 010; each frame issues 16 word writes.
REQ-042 req_i=3'b111 simultaneously -> source 0 is served first; then 1 and 2 in round-robin order.
REQ-043 len=0 and len=509 -> err_o pulse for the source, no bus writes, GAP of 16 cycles.
REQ-044 bus_rdata_i[15] stuck at 1 -> exactly 1024 poll reads, then an err_o pulse, then GAP.
REQ-045 Reset asserted in COPY at idx 5 -> all outputs 0 immediately; after release, a pending request restarts from idx 0.

Source files
------------

// File: rtl/tx_buf_sched.sv
// tx_buf_sched: arbitrates three frame sources, copies the granted frame
// into the tx PTP buffer, kicks the transmitter and polls for completion.
//
// Ports:
//   bus2ip_clk, bus2ip_rst_n   clock, asynchronous active-low reset
//   req_i[2:0], len_i[26:0]    per-source request and 9-bit octet length
//   grant_o[2:0]               one-hot grant, held for the whole frame
//   word_rd_o, word_idx_o,     frame word fetch from the granted source;
//   word_data_i                data is returned in the same cycle
//   bus_addr_o, bus_wdata_o,   single-cycle bus master (one word per cycle)
//   bus_wr_o, bus_rd_o,
//   bus_rdata_i
//   done_o[2:0], err_o[2:0]    one-cycle completion / error pulses
module tx_buf_sched #(
    parameter logic [31:0] TX_BUF_BADDR = 32'h2000,
    parameter int          GAP_CYCLES   = 16,
    parameter int          POLL_LIMIT   = 1024
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic [2:0]  req_i,
    input  logic [26:0] len_i,
    output logic [2:0]  grant_o,
    output logic        word_rd_o,
    output logic [6:0]  word_idx_o,
    input  logic [31:0] word_data_i,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic        bus_wr_o,
    output logic        bus_rd_o,
    input  logic [31:0] bus_rdata_i,
    output logic [2:0]  done_o,
    output logic [2:0]  err_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARB  = 3'd1;
    localparam logic [2:0] S_COPY = 3'd2;
    localparam logic [2:0] S_KICK = 3'd3;
    localparam logic [2:0] S_POLL = 3'd4;
    localparam logic [2:0] S_GAP  = 3'd5;

    localparam int GW = $clog2(GAP_CYCLES + 128) + 1;
    localparam int PW = $clog2(POLL_LIMIT + 1) + 1;

    localparam logic [31:0]   CTRL_ADDR = TX_BUF_BADDR + 32'h200;
    localparam logic [GW-1:0] GAP_LD    = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [8:0]    len_q, len_d;
    logic [6:0]    idx_q, idx_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [GW-1:0] gap_q, gap_d;
    // 0: source 1 wins the next 1-vs-2 tie, 1: source 2 wins it
    logic          rr_q, rr_d;

    logic [6:0] nw;
    logic       len_bad;
    logic       copy_act;
    logic       poll_done;
    logic       poll_tmo;
    logic [2:0] pick;
    logic [8:0] pick_len;
    logic       unused_rdata;

    assign nw       = 7'(({1'b0, len_q} + 10'd3) >> 2);
    assign len_bad  = (len_q == 9'd0) || (len_q > 9'd508);
    assign copy_act = (state_q == S_COPY) && !len_bad;

    // The first poll read is never trusted: the kick may not have
    // propagated yet, so completion needs at least a second read.
    assign poll_done = (state_q == S_POLL) && !bus_rdata_i[15]
                       && (poll_q != '0);
    assign poll_tmo  = (state_q == S_POLL) && (poll_q == POLL_LAST)
                       && !poll_done;

    assign unused_rdata = ^{bus_rdata_i[31:16], bus_rdata_i[14:0]};

    assign grant_o = grant_q;

    always_comb begin
        pick = 3'b000;
        if (req_i[0]) begin
            pick = 3'b001;
        end else if (req_i[1] && req_i[2]) begin
            pick = rr_q ? 3'b100 : 3'b010;
        end else if (req_i[1]) begin
            pick = 3'b010;
        end else if (req_i[2]) begin
            pick = 3'b100;
        end
    end

    always_comb begin
        pick_len = len_i[8:0];
        if (pick[1]) pick_len = len_i[17:9];
        if (pick[2]) pick_len = len_i[26:18];
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        len_d   = len_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        gap_d   = gap_q;
        rr_d    = rr_q;
        unique case (state_q)
            S_IDLE: begin
                if (|req_i) state_d = S_ARB;
            end
            S_ARB: begin
                if (|req_i) begin
                    grant_d = pick;
                    len_d   = pick_len;
                    idx_d   = 7'd0;
                    state_d = S_COPY;
                    if (pick[1]) rr_d = 1'b1;
                    if (pick[2]) rr_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COPY: begin
                // A bad length spends this single cycle reporting the
                // error with grant still up, then goes straight to GAP.
                if (len_bad) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                    gap_d   = GAP_LD;
                end else if (idx_q == nw - 7'd1) begin
                    state_d = S_KICK;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            S_KICK: begin
                state_d = S_POLL;
                poll_d  = '0;
            end
            S_POLL: begin
                if (poll_done || poll_tmo) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                    gap_d   = GAP_LD + GW'(nw);
                end else begin
                    poll_d = poll_q + PW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        word_rd_o   = 1'b0;
        word_idx_o  = 7'd0;
        bus_wr_o    = 1'b0;
        bus_rd_o    = 1'b0;
        bus_addr_o  = 32'd0;
        bus_wdata_o = 32'd0;
        done_o      = 3'b000;
        err_o       = 3'b000;
        if (copy_act) begin
            word_rd_o   = 1'b1;
            word_idx_o  = idx_q;
            bus_wr_o    = 1'b1;
            bus_addr_o  = TX_BUF_BADDR + {23'd0, idx_q, 2'b00};
            bus_wdata_o = word_data_i;
        end
        if (state_q == S_KICK) begin
            bus_wr_o    = 1'b1;
            bus_addr_o  = CTRL_ADDR;
            bus_wdata_o = {16'd0, 1'b1, 6'd0, len_q};
        end
        if (state_q == S_POLL) begin
            bus_rd_o   = 1'b1;
            bus_addr_o = CTRL_ADDR;
        end
        if ((state_q == S_COPY) && len_bad) err_o = grant_q;
        if (poll_done) done_o = grant_q;
        if (poll_tmo) err_o = grant_q;
    end

    always_ff @(posedge bus2ip_clk or negedge bus2ip_rst_n) begin
        if (!bus2ip_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 3'b000;
            len_q   <= 9'd0;
            idx_q   <= 7'd0;
            poll_q  <= '0;
            gap_q   <= '0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            rr_q    <= rr_d;
        end
    end

endmodule

// File: tb/tb_tx_buf_sched.sv
// tb_tx_buf_sched: randomized frame-level bench for tx_buf_sched.
// Frames are predicted from a transaction model (arbitration, word list, gap).
module tb_tx_buf_sched;

    localparam int          GAP   = 16;
    localparam int          PLIM  = 1024;
    localparam logic [31:0] BADDR = 32'h2000;
    localparam logic [31:0] CTRL  = 32'h2200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_i;
    logic [26:0] len_i;
    logic [2:0]  grant_o;
    logic        word_rd_o;
    logic [6:0]  word_idx_o;
    logic [31:0] word_data_i;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_wr_o;
    logic        bus_rd_o;
    logic [31:0] bus_rdata_i;
    logic [2:0]  done_o;
    logic [2:0]  err_o;

    int n_chk = 0;
    int n_fail = 0;
    int model_rr = 1;
    int next_wait = 0;

    logic [31:0] mem [3][128];
    logic [1:0]  gsrc;

    tx_buf_sched dut (
        .bus2ip_clk   (clk),
        .bus2ip_rst_n (rst_n),
        .req_i        (req_i),
        .len_i        (len_i),
        .grant_o      (grant_o),
        .word_rd_o    (word_rd_o),
        .word_idx_o   (word_idx_o),
        .word_data_i  (word_data_i),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_wr_o     (bus_wr_o),
        .bus_rd_o     (bus_rd_o),
        .bus_rdata_i  (bus_rdata_i),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        gsrc = 2'd0;
        if (grant_o[1]) gsrc = 2'd1;
        if (grant_o[2]) gsrc = 2'd2;
    end

    assign word_data_i = mem[gsrc][word_idx_o];

    function automatic logic [2:0] pick(input logic [2:0] r);
        if (r[0]) return 3'b001;
        if (r[1] && r[2]) return (model_rr == 1) ? 3'b010 : 3'b100;
        if (r[1]) return 3'b010;
        if (r[2]) return 3'b100;
        return 3'b000;
    endfunction

    function automatic int src_of(input logic [2:0] g);
        if (g[2]) return 2;
        if (g[1]) return 1;
        return 0;
    endfunction

    function automatic logic [26:0] mk_lens(input int l0, input int l1,
                                            input int l2);
        return {9'(l2), 9'(l1), 9'(l0)};
    endfunction

    function automatic int rand_len();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) begin
            if ($urandom_range(0, 1) == 0) return 0;
            return int'($urandom_range(509, 511));
        end
        if (r == 1) return 508;
        return int'($urandom_range(1, 508));
    endfunction

    function automatic logic [26:0] rand_lens();
        return mk_lens(rand_len(), rand_len(), rand_len());
    endfunction

    task automatic drain();
        req_i = 3'b000;
        repeat (GAP + 150) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_rr = 1;
        @(negedge clk);
    endtask

    // Runs one frame from its grant to the first GAP cycle.
    task automatic do_frame(input logic [2:0] exp_g, input int busy,
                            input bit chk_wait, input logic [2:0] req_after,
                            input logic [26:0] len_after);
        int w, src, len, nw, k, exp_reads, fi;
        bit quiet, ok, bad, pulse;
        logic [2:0] pd, pe;
        logic [31:0] ea, ed, aa, ad, fea, fed;
        w = 0;
        quiet = 1'b1;
        pd = 3'b000;
        pe = 3'b000;
        fi = 0; aa = 0; ad = 0; fea = 0; fed = 0;
        while (grant_o === 3'b000 && w < 400) begin
            if (bus_wr_o || bus_rd_o || word_rd_o || done_o != 0 || err_o != 0)
                quiet = 1'b0;
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (grant_o !== exp_g) begin
            n_fail++;
            $display("FAIL grant: got %b want %b after %0d cycles",
                     grant_o, exp_g, w);
        end
        if (grant_o === 3'b000) return;
        if (chk_wait) begin
            n_chk++;
            if (w != next_wait) begin
                n_fail++;
                $display("FAIL gap_len: grant after %0d cycles want %0d",
                         w, next_wait);
            end
            n_chk++;
            if (!quiet) begin
                n_fail++;
                $display("FAIL gap_quiet: strobe/pulse seen got 1 want 0");
            end
        end
        src = src_of(exp_g);
        len = int'(len_i[9*src +: 9]);
        if (exp_g == 3'b010) model_rr = 2;
        else if (exp_g == 3'b100) model_rr = 1;
        req_i = req_after;
        len_i = len_after;
        bad = (len == 0) || (len > 508);
        nw = (len + 3) / 4;
        if (bad) begin
            n_chk++;
            if (err_o !== exp_g || done_o !== 3'b000 || bus_wr_o !== 1'b0 ||
                bus_rd_o !== 1'b0 || word_rd_o !== 1'b0) begin
                n_fail++;
                $display("FAIL len_err: err=%b done=%b wr=%b rd=%b want err=%b",
                         err_o, done_o, bus_wr_o, bus_rd_o, exp_g);
            end
            next_wait = GAP + 2;
        end else begin
            ok = 1'b1;
            for (int i = 0; i < nw; i++) begin
                ea = BADDR + 32'(4 * i);
                ed = mem[src][i];
                if (ok && !(word_rd_o === 1'b1 && word_idx_o === 7'(i) &&
                            bus_wr_o === 1'b1 && bus_rd_o === 1'b0 &&
                            bus_addr_o === ea && bus_wdata_o === ed &&
                            grant_o === exp_g && done_o === 3'b000 &&
                            err_o === 3'b000)) begin
                    ok = 1'b0;
                    fi = i;
                    aa = bus_addr_o;
                    ad = bus_wdata_o;
                    fea = ea;
                    fed = ed;
                end
                @(negedge clk);
            end
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL copy: word %0d addr %h data %h want %h %h",
                         fi, aa, ad, fea, fed);
            end
            ed = 32'h0000_8000 | 32'(len);
            n_chk++;
            if (!(bus_wr_o === 1'b1 && bus_rd_o === 1'b0 &&
                  word_rd_o === 1'b0 && bus_addr_o === CTRL &&
                  bus_wdata_o === ed)) begin
                n_fail++;
                $display("FAIL kick: wr=%b addr %h data %h want %h %h",
                         bus_wr_o, bus_addr_o, bus_wdata_o, CTRL, ed);
            end
            @(negedge clk);
            k = 0;
            pulse = 1'b0;
            ok = 1'b1;
            while (!pulse && k < PLIM + 8) begin
                bus_rdata_i = ($urandom() & 32'hFFFF_7FFF) |
                              ((k < busy) ? 32'h0000_8000 : 32'h0);
                #1;
                if (!(bus_rd_o === 1'b1 && bus_wr_o === 1'b0 &&
                      word_rd_o === 1'b0 && bus_addr_o === CTRL &&
                      bus_wdata_o === 32'h0 && grant_o === exp_g))
                    ok = 1'b0;
                k++;
                if (done_o !== 3'b000 || err_o !== 3'b000) begin
                    pulse = 1'b1;
                    pd = done_o;
                    pe = err_o;
                end else begin
                    @(negedge clk);
                end
            end
            exp_reads = (busy >= PLIM) ? PLIM : ((busy < 1) ? 1 : busy) + 1;
            n_chk++;
            if (!ok) begin
                n_fail++;
                $display("FAIL poll_bus: rd=%b wr=%b addr %h want rd=1 addr %h",
                         bus_rd_o, bus_wr_o, bus_addr_o, CTRL);
            end
            n_chk++;
            if (k != exp_reads) begin
                n_fail++;
                $display("FAIL poll_count: got %0d reads want %0d", k, exp_reads);
            end
            n_chk++;
            if (busy >= PLIM) begin
                if (pe !== exp_g || pd !== 3'b000) begin
                    n_fail++;
                    $display("FAIL timeout: err=%b done=%b want err=%b",
                             pe, pd, exp_g);
                end
            end else if (pd !== exp_g || pe !== 3'b000) begin
                n_fail++;
                $display("FAIL done: done=%b err=%b want done=%b",
                         pd, pe, exp_g);
            end
            next_wait = GAP + nw + 2;
        end
        @(negedge clk);
        bus_rdata_i = 32'h0000_8000;
        n_chk++;
        if (grant_o !== 3'b000 || done_o !== 3'b000 || err_o !== 3'b000) begin
            n_fail++;
            $display("FAIL release: grant=%b done=%b err=%b want all 0",
                     grant_o, done_o, err_o);
        end
    endtask

    task automatic test_reset();
        bit seen;
        rst_n = 1'b0;
        req_i = 3'b111;
        len_i = mk_lens(60, 64, 64);
        repeat (2) @(negedge clk);
        n_chk++;
        if (grant_o !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_grant: got %b want 000", grant_o);
        end
        n_chk++;
        if ({bus_wr_o, bus_rd_o, word_rd_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_strobe: got %b want 000",
                     {bus_wr_o, bus_rd_o, word_rd_o});
        end
        n_chk++;
        if ({bus_addr_o, bus_wdata_o, word_idx_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus: addr %h data %h idx %0d want 0",
                     bus_addr_o, bus_wdata_o, word_idx_o);
        end
        n_chk++;
        if ({done_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL rst_pulse: done=%b err=%b want 0", done_o, err_o);
        end
        req_i = 3'b000;
        rst_n = 1'b1;
        model_rr = 1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (grant_o !== 3'b000 || bus_wr_o !== 1'b0 || bus_rd_o !== 1'b0)
                seen = 1'b1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL idle_quiet: activity got 1 want 0 with no request");
        end
    endtask

    task automatic test_single();
        drain();
        len_i = mk_lens(60, 1, 1);
        req_i = 3'b001;
        do_frame(3'b001, 0, 1'b0, 3'b001, len_i);
        do_frame(3'b001, 3, 1'b1, 3'b000, len_i);
    endtask

    task automatic test_back_to_back();
        drain();
        len_i = mk_lens(4, 64, 64);
        req_i = 3'b110;
        do_frame(3'b010, 1, 1'b0, 3'b110, len_i);
        do_frame(3'b100, 2, 1'b1, 3'b110, len_i);
        do_frame(3'b010, 0, 1'b1, 3'b000, len_i);
    endtask

    task automatic test_priority();
        logic [26:0] l;
        drain();
        do_reset();
        l = mk_lens(int'($urandom_range(1, 508)), int'($urandom_range(1, 508)),
                    int'($urandom_range(1, 508)));
        len_i = l;
        req_i = 3'b111;
        do_frame(3'b001, 0, 1'b0, 3'b110, l);
        do_frame(3'b010, 2, 1'b1, 3'b110, l);
        do_frame(3'b100, 1, 1'b1, 3'b000, l);
    endtask

    task automatic test_bad_len();
        drain();
        len_i = mk_lens(40, 0, 509);
        req_i = 3'b010;
        do_frame(3'b010, 0, 1'b0, 3'b100, len_i);
        do_frame(3'b100, 0, 1'b1, 3'b001, len_i);
        do_frame(3'b001, 1, 1'b1, 3'b000, len_i);
    endtask

    task automatic test_timeout();
        logic [2:0] g;
        drain();
        g = 3'(1 << $urandom_range(0, 2));
        len_i = rand_lens();
        len_i[9*src_of(g) +: 9] = 9'($urandom_range(1, 508));
        req_i = g;
        do_frame(g, PLIM + 100, 1'b0, g, len_i);
        do_frame(g, 0, 1'b1, 3'b000, len_i);
    endtask

    task automatic test_reset_mid();
        int w;
        bit pulsed;
        drain();
        len_i = mk_lens(8, 100, 8);
        req_i = 3'b010;
        w = 0;
        while (!(word_rd_o === 1'b1 && word_idx_o === 7'd5) && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_chk++;
        if (w >= 200) begin
            n_fail++;
            $display("FAIL reach_idx5: waited %0d cycles want < 200", w);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({grant_o, word_rd_o, word_idx_o, bus_wr_o, bus_rd_o, bus_addr_o,
             bus_wdata_o, done_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: grant=%b wr=%b idx=%0d addr %h want 0",
                     grant_o, bus_wr_o, word_idx_o, bus_addr_o);
        end
        pulsed = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o !== 3'b000 || err_o !== 3'b000 || grant_o !== 3'b000)
                pulsed = 1'b1;
        end
        n_chk++;
        if (pulsed) begin
            n_fail++;
            $display("FAIL mid_reset_pulse: got activity 1 want 0 in reset");
        end
        rst_n = 1'b1;
        model_rr = 1;
        do_frame(3'b010, 0, 1'b0, 3'b000, len_i);
    endtask

    task automatic test_random();
        logic [2:0] rq, nrq, g;
        logic [26:0] nl;
        drain();
        rq = 3'($urandom_range(1, 7));
        len_i = rand_lens();
        req_i = rq;
        for (int i = 0; i < 24; i++) begin
            g = pick(rq);
            nrq = (i == 23) ? 3'b000 : 3'($urandom_range(1, 7));
            nl = rand_lens();
            do_frame(g, int'($urandom_range(0, 6)), i > 0, nrq, nl);
            rq = nrq;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_i = 3'b000;
        len_i = '0;
        bus_rdata_i = 32'h0000_8000;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 128; i++)
                mem[s][i] = $urandom();
        test_reset();
        test_single();
        test_back_to_back();
        test_priority();
        test_bad_len();
        test_timeout();
        test_reset_mid();
        test_random();
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
